compare_sar_driver: RTL and testbench
=====================================

Name: compare_sar_driver

Overview:
- Drives the B operand of a registered magnitude comparator and consumes its GT/LT/EQ flags, so it sits at the other end of the comparator's interface.
- On start, it binary-searches (successive approximation, MSB first) for the unsigned value on the comparator's A input.
- It returns that value as result, with early exit on EQ.
- Used wherever a value is observable only through compare flags, e.g. threshold and level search.

Parameters:
N, 4, operand width in bits; must match the width of the attached comparator.

Ports:
clk  input  1  rising-edge clock shared with the comparator
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a search; ignored while busy=1
GT  input  1  registered comparator flag: A > trial
LT  input  1  registered comparator flag: A < trial
EQ  input  1  registered comparator flag: A == trial
trial  output  N  registered probe value, wired to the comparator's B input
result  output  N  search result; valid when done=1, held until the next accepted start
busy  output  1  high from the cycle after an accepted start until done or err
done  output  1  one-cycle pulse: result is valid
err  output  1  one-cycle pulse: flags were not one-hot during EVAL, search aborted

Behaviour:
- Reset (asynchronous, active-low): trial=0, result=0, busy=0, done=0, err=0, state=IDLE, internal acc=0, bit index idx=N-1.
- Comparator contract: the comparator registers its flags one edge after trial changes. The driver therefore spends 2 cycles per bit:
  - PROBE: trial stable, comparator capturing.
  - EVAL: flags valid for the current trial.
- States: IDLE, PROBE, EVAL. All outputs are registered.
- IDLE:
  - On start=1: acc<=0, idx<=N-1, trial<=1<<(N-1), busy<=1, go to PROBE.
  - done and err are cleared to 0 on every cycle not explicitly pulsing them.
- PROBE: unconditionally go to EVAL next edge; no register changes.
- EVAL (flags sampled at this edge), priority order:
  1. Flags not exactly one-hot (000, or two or more set): err<=1, busy<=0, go to IDLE. result is unchanged and trial holds its value.
  2. EQ=1: result<=trial, done<=1, busy<=0, go to IDLE (early exit).
  3. GT=1: new_acc=trial (keep the bit).
  4. LT=1: new_acc=acc (drop the bit).
  5. If idx==0 (for cases 3 or 4): result<=new_acc, done<=1, busy<=0, go to IDLE.
  6. Otherwise (for cases 3 or 4): acc<=new_acc, idx<=idx-1, trial<=new_acc | (1<<(idx-1)), go to PROBE.
- Arithmetic:
  - All values are unsigned N-bit; no carries are possible because the trial bits are disjoint.
  - The final result always equals A, provided A is held stable during the search.
- Latency, counted from the edge that samples start to the edge that raises done:
  - 2*k cycles, where k = number of probes, 1 <= k <= N.
  - Worst case 2N; best case 2, when A = 2^(N-1).
- trial holds its last value after done/err.
- start while busy is ignored. start in the same cycle as done/err (the IDLE return edge) is not seen; it must be presented while state=IDLE.
- reset_n asserted mid-search: immediate return to reset values. The comparator's own reset drives its flags to 000. If only the comparator is reset mid-search, the next EVAL raises err.
- A changing mid-search is not detected. result is then undefined but still N-bit and still accompanied by done.

Test Plan:
1. N=4, A=11, pulse start: trial sequence 8,12,10,11 (GT,LT,GT,EQ) -> done pulses 8 cycles after start edge, result=11, busy low same edge.
2. A=8: single probe trial=8 EQ -> done after 2 cycles, result=8; A=0: trials 8,4,2,1 all LT -> done after 8 cycles, result=0.
3. A=15: trials 8,12,14,15 -> EQ on 4th probe, result=15. Then A=13 with a new start: trials 8,12,14,13 -> result=13, proving acc/idx are reinitialised per search.
4. Force flags to 000 by holding the comparator's reset_n low during the first EVAL -> err pulse 2 cycles after start, done stays 0, result keeps its prior value, state returns to IDLE.
5. Pulse start again while busy=1 (A=5) -> ignored, trial sequence undisturbed (8,4,6,5), single done, result=5.
6. Assert reset_n low during the second PROBE -> trial, result, busy, done, err all 0 immediately. After release, IDLE accepts a new start and returns the correct value (A=6 -> result=6).

Source files
------------

// File: rtl/compare_sar_driver_if.sv
// Bundles the request/result handshake with the comparator-facing probe and flag lines.
// master is the SAR driver; slave is whatever owns start and the comparator.
interface compare_sar_driver_if #(
   parameter int N = 4
);
   logic         start;
   logic         GT;
   logic         LT;
   logic         EQ;
   logic [N-1:0] trial;
   logic [N-1:0] result;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      input  start, GT, LT, EQ,
      output trial, result, busy, done, err
   );

   modport slave (
      output start, GT, LT, EQ,
      input  trial, result, busy, done, err
   );
endinterface

// File: rtl/compare_sar_driver.sv
// Successive-approximation driver for a registered magnitude comparator: probes B MSB-first
// and recovers the unsigned value on the comparator's A input from its GT/LT/EQ flags.
module compare_sar_driver #(
   parameter int N = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   compare_sar_driver_if.master  bus
);
   localparam int           IW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] ONE_V = N'(1);
   localparam logic [N-1:0] MSB_V = ONE_V << (N - 1);
   localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      PROBE,
      EVAL
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  trial_q, trial_d;
   logic [N-1:0]  result_q, result_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          flags_ok;
   logic [N-1:0]  new_acc;
   logic [N-1:0]  next_bit;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      trial_d  = trial_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      flags_ok = $onehot({bus.GT, bus.LT, bus.EQ});
      // GT keeps the probed bit, LT drops it; trial bits are disjoint so OR never carries.
      new_acc  = bus.GT ? trial_q : acc_q;
      next_bit = ONE_V << (idx_q - IW'(1));

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d   = '0;
               idx_d   = TOP_IDX;
               trial_d = MSB_V;
               busy_d  = 1'b1;
               state_d = PROBE;
            end
         end
         PROBE: begin
            state_d = EVAL;
         end
         EVAL: begin
            if (!flags_ok) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (bus.EQ) begin
               result_d = trial_q;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else if (idx_q == '0) begin
               result_d = new_acc;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               acc_d   = new_acc;
               idx_d   = idx_q - IW'(1);
               trial_d = new_acc | next_bit;
               state_d = PROBE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         idx_q    <= TOP_IDX;
         trial_q  <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.trial  = trial_q;
   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.err    = err_q;
endmodule

// File: tb/tb_compare_sar_driver.sv
// Scoreboard bench for compare_sar_driver: a registered comparator model feeds the flags,
// expected trials/results/latencies are queued at stimulus time and popped by a monitor.
module tb_compare_sar_driver;
   localparam int N   = 4;
   localparam int TMO = 4 * N + 8;

   logic         clk       = 1'b0;
   logic         reset_n   = 1'b0;
   logic         cmp_rst_n = 1'b0;
   logic [N-1:0] a_val     = '0;

   compare_sar_driver_if #(.N(N)) bus ();

   compare_sar_driver #(.N(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Registered comparator on the far side of the interface: flags follow trial by one edge.
   always @(posedge clk or negedge cmp_rst_n) begin
      if (!cmp_rst_n) begin
         bus.GT <= 1'b0;
         bus.LT <= 1'b0;
         bus.EQ <= 1'b0;
      end else begin
         bus.GT <= (a_val > bus.trial);
         bus.LT <= (a_val < bus.trial);
         bus.EQ <= (a_val == bus.trial);
      end
   end

   typedef struct {
      int res;
      bit is_err;
      int lat;
      int start_edge;
   } exp_t;

   exp_t exp_q[$];
   int   trial_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   last_res = 0;

   task automatic checkOutput(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected trial per new probe value and one entry per done/err pulse.
   initial begin : monitor
      bit   prev_busy;
      int   prev_trial;
      exp_t e;
      prev_busy  = 1'b0;
      prev_trial = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_busy = 1'b0;
            continue;
         end
         if (bus.busy && (!prev_busy || int'(bus.trial) != prev_trial)) begin
            if (trial_q.size() == 0) checkOutput("unexpected_trial", int'(bus.trial), -1);
            else                     checkOutput("trial", int'(bus.trial), trial_q.pop_front());
         end
         prev_busy  = bus.busy;
         prev_trial = int'(bus.trial);
         if (bus.done || bus.err) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_completion", int'({bus.done, bus.err}), 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("err_flag", int'(bus.err), int'(e.is_err));
               checkOutput("done_flag", int'(bus.done), int'(!e.is_err));
               checkOutput("result", int'(bus.result), e.res);
               checkOutput("latency", cyc - e.start_edge, e.lat);
               checkOutput("busy_at_end", int'(bus.busy), 0);
            end
         end
      end
   end

   // mode 0: plain search, 1: extra start while busy, 2: comparator reset during first EVAL,
   // 3: driver reset during second PROBE.
   task automatic applyStimulus(input int a, input int mode);
      exp_t e;
      int   probes;
      int   val;
      int   t;
      bit   seen;
      probes = 0;
      val    = 0;
      seen   = 1'b0;
      @(negedge clk);
      a_val     = a[N-1:0];
      bus.start = 1'b1;
      if (mode == 2) begin
         trial_q.push_back(1 << (N - 1));
         e = '{res: last_res, is_err: 1'b1, lat: 2, start_edge: cyc + 1};
      end else begin
         for (int b = N - 1; b >= 0; b--) begin
            t = val + (1 << b);
            trial_q.push_back(t);
            probes++;
            if (t == a) break;
            if (a > t) val = t;
         end
         e = '{res: a, is_err: 1'b0, lat: 2 * probes, start_edge: cyc + 1};
      end
      exp_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      if (mode == 3) begin
         @(negedge clk);
         @(negedge clk);
         reset_n = 1'b0;
         #1;
         checkOutput("rst_trial", int'(bus.trial), 0);
         checkOutput("rst_result", int'(bus.result), 0);
         checkOutput("rst_busy", int'(bus.busy), 0);
         checkOutput("rst_done", int'(bus.done), 0);
         checkOutput("rst_err", int'(bus.err), 0);
         exp_q.delete();
         trial_q.delete();
         last_res = 0;
         @(negedge clk);
         reset_n = 1'b1;
         return;
      end
      for (int i = 0; i < TMO; i++) begin
         if (mode == 2 && i == 1) cmp_rst_n = 1'b0;
         if (mode == 1 && i == 1) bus.start = 1'b1;
         if (mode == 1 && i == 2) bus.start = 1'b0;
         if (bus.done || bus.err) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      cmp_rst_n = 1'b1;
      if (!seen) begin
         checkOutput("completion_timeout", 0, 1);
         exp_q.delete();
         trial_q.delete();
      end
      if (mode != 2) last_res = a;
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_trial", int'(bus.trial), 0);
      checkOutput("reset_result", int'(bus.result), 0);
      checkOutput("reset_busy", int'(bus.busy), 0);
      checkOutput("reset_done", int'(bus.done), 0);
      checkOutput("reset_err", int'(bus.err), 0);
      reset_n   = 1'b1;
      cmp_rst_n = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus(11, 0);
      applyStimulus(8, 0);
      applyStimulus(0, 0);
      applyStimulus(15, 0);
      applyStimulus(13, 0);
      applyStimulus(3, 2);
      applyStimulus(5, 1);
      applyStimulus(6, 3);
      applyStimulus(6, 0);
      for (int n = 0; n < 40; n++) begin
         applyStimulus(int'($urandom_range((1 << N) - 1, 0)), ($urandom_range(3, 0) == 0) ? 1 : 0);
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size() + trial_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
